// File: rtl/divider_restoring_radix.sv
// Multi-cycle restoring divider with signed/unsigned operation, BITS_PER_CYCLE quotient bits per iteration,
// divide-by-zero and signed-overflow flags. Handshake: start accepted when idle; done held until next accept.
module divider_restoring_radix #(
  parameter int DIV_NUM_BITS   = 8,
  parameter int DIV_DEN_BITS   = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    CLK,
  input  logic                    SRST,
  input  logic                    CE,
  input  logic [DIV_NUM_BITS-1:0] NUMERATOR_IN,
  input  logic [DIV_DEN_BITS-1:0] DENOMINATOR_IN,
  input  logic                    signed_mode,
  input  logic                    start,
  output logic [DIV_NUM_BITS-1:0] QUOTENT_OUT,
  output logic [DIV_DEN_BITS-1:0] REMAINDER_OUT,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    ovf
);

  localparam int NB    = DIV_NUM_BITS;
  localparam int DB    = DIV_DEN_BITS;
  localparam int RW    = DB + 1;
  localparam int K     = NB / BITS_PER_CYCLE;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [NB-1:0] NUM_MIN = {1'b1, {(NB-1){1'b0}}};

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
      (NB % BITS_PER_CYCLE) != 0 || NB < 2 || DB < 2 || DB > NB) begin : g_cfg_err
    $error("divider_restoring_radix: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [NB-1:0]     dvd_q, dvd_d;     // raw numerator, then magnitude, then quotient as bits shift in
  logic [DB-1:0]     den_q, den_d;     // raw denominator, then magnitude
  logic [RW-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              smode_q, smode_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              ovfp_q, ovfp_d;
  logic [NB-1:0]     quot_q, quot_d;
  logic [DB-1:0]     remo_q, remo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              ovf_q, ovf_d;

  logic              num_neg_s, den_neg_s, ovf_det_s;
  logic [NB-1:0]     num_mag_s;
  logic [DB-1:0]     den_mag_s;
  logic [RW-1:0]     it_rem_s;
  logic [NB-1:0]     it_dvd_s;
  logic [RW:0]       it_shift_s;

  assign num_neg_s = smode_q & dvd_q[NB-1];
  assign den_neg_s = smode_q & den_q[DB-1];
  assign num_mag_s = num_neg_s ? -dvd_q : dvd_q;
  assign den_mag_s = den_neg_s ? -den_q : den_q;
  assign ovf_det_s = smode_q && (dvd_q == NUM_MIN) && (den_q == {DB{1'b1}});

  // Chained restoring steps resolved in one iteration cycle
  always_comb begin
    it_rem_s   = rem_q;
    it_dvd_s   = dvd_q;
    it_shift_s = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      it_shift_s = {it_rem_s, it_dvd_s[NB-1]};
      if (it_shift_s >= {2'b00, den_q}) begin
        it_rem_s = RW'(it_shift_s - {2'b00, den_q});
        it_dvd_s = {it_dvd_s[NB-2:0], 1'b1};
      end else begin
        it_rem_s = it_shift_s[RW-1:0];
        it_dvd_s = {it_dvd_s[NB-2:0], 1'b0};
      end
    end
  end

  // Next-state and output-register logic
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    den_d   = den_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    smode_d = smode_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovfp_d  = ovfp_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = NUMERATOR_IN;
          den_d   = DENOMINATOR_IN;
          smode_d = signed_mode;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (den_q == '0) begin
          quot_d  = '1;
          remo_d  = dvd_q[DB-1:0];
          done_d  = 1'b1;
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          dvd_d   = num_mag_s;
          den_d   = den_mag_s;
          qneg_d  = num_neg_s ^ den_neg_s;
          rneg_d  = num_neg_s;
          ovfp_d  = ovf_det_s;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        dvd_d = it_dvd_s;
        rem_d = it_rem_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX: begin
        // Truncation toward zero: remainder follows the numerator's sign
        quot_d  = qneg_q ? -dvd_q : dvd_q;
        remo_d  = rneg_q ? -rem_q[DB-1:0] : rem_q[DB-1:0];
        ovf_d   = ovfp_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over clock enable
  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      smode_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      smode_q <= smode_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovfp_q  <= ovfp_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      ovf_q   <= ovf_d;
    end
  end

  assign QUOTENT_OUT   = quot_q;
  assign REMAINDER_OUT = remo_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign ovf           = ovf_q;

endmodule
